// File: rtl/ct_lsu_spsram_512x54_ctrl.sv
// Access controller for a 512x54 single-port SRAM: read/write round-robin arbitration,
// 1-cycle read return, and an optional array clear sequencer (`CT_LSU_SPSRAM_CTRL_INIT_EN).
module ct_lsu_spsram_512x54_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 54,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  blk;      // requesters locked out this cycle
  logic                  clr_act;  // sequencer owns the SRAM port this cycle
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rr_ptr;   // 0 = read side wins next contention
  logic                  vld_p1;

`ifdef CT_LSU_SPSRAM_CTRL_INIT_EN
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy_r;
  logic                  done_r;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == '1) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          cnt    <= '0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // A clear request in IDLE already blocks the requesters for that cycle.
  assign blk       = cpurst | busy_r | done_r | ((state == IDLE) & init_req);
  assign clr_act   = busy_r;
  assign clr_addr  = cnt;
  assign init_busy = busy_r;
  assign init_done = done_r;
`else
  logic unused_cfg;

  assign unused_cfg = ^{init_req, INIT_DATA};
  assign blk        = cpurst;
  assign clr_act    = 1'b0;
  assign clr_addr   = '0;
  assign init_busy  = 1'b0;
  assign init_done  = 1'b0;
`endif

  assign rd_gnt = rd_req & ~blk & (~wr_req | ~rr_ptr);
  assign wr_gnt = wr_req & ~blk & (~rd_req |  rr_ptr);

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rr_ptr <= 1'b0;
    end else if (rd_req & wr_req & ~blk) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (clr_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = clr_addr;
      sram_d    = INIT_DATA;
    end else if (rd_gnt) begin
      sram_cen = 1'b0;
      sram_a   = rd_addr;
    end else if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_mask;
      sram_a    = wr_addr;
      sram_d    = wr_data;
    end
  end

  // stage p1: SRAM read data returns one cycle after the grant
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_gnt;
    end
  end

  assign rd_vld  = vld_p1;
  assign rd_data = vld_p1 ? sram_q : '0;

endmodule

// File: tb/tb_ct_lsu_spsram_512x54_ctrl.sv
// Directed bench for ct_lsu_spsram_512x54_ctrl with a behavioural 512x54 bit-write SRAM;
// clear-sequencer sequences run when CT_LSU_SPSRAM_CTRL_INIT_EN is defined.
module tb_ct_lsu_spsram_512x54_ctrl;

  localparam logic [53:0] ALL1 = {54{1'b1}};
  localparam logic [53:0] B    = 54'h20000000000000;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        rd_req, wr_req, init_req;
  logic [8:0]  rd_addr, wr_addr;
  logic [53:0] wr_data, wr_mask;
  logic        rd_gnt, rd_vld, wr_gnt, init_busy, init_done;
  logic [53:0] rd_data;
  logic        sram_cen, sram_gwen;
  logic [53:0] sram_wen, sram_d, sram_q;
  logic [8:0]  sram_a;

  int n_chk  = 0;
  int n_fail = 0;
  logic preload = 1'b1;
  logic [53:0] mem [512];

  always #5 clk = ~clk;

  ct_lsu_spsram_512x54_ctrl dut (
    .forever_cpuclk(clk), .cpurst(cpurst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM model: active-low controls, per-bit write enable, registered read data
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= {1'b1, 44'h0, 9'(i)};
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  typedef struct {
    logic rr; logic [8:0] ra; logic wr; logic [8:0] wa; logic [53:0] wd; logic [53:0] wm;
    logic egr; logic egw; logic ecen; logic egwen; logic [53:0] ewen; logic [8:0] ea;
    logic [53:0] ed; logic evld; logic [53:0] erd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".rd_gnt"},    64'(rd_gnt),    64'(0));
    chk({tag, ".wr_gnt"},    64'(wr_gnt),    64'(0));
    chk({tag, ".rd_vld"},    64'(rd_vld),    64'(0));
    chk({tag, ".rd_data"},   64'(rd_data),   64'(0));
    chk({tag, ".init_busy"}, 64'(init_busy), 64'(0));
    chk({tag, ".init_done"}, 64'(init_done), 64'(0));
    chk({tag, ".cen"},       64'(sram_cen),  64'(1));
    chk({tag, ".gwen"},      64'(sram_gwen), 64'(1));
    chk({tag, ".wen"},       64'(sram_wen),  64'(ALL1));
    chk({tag, ".a"},         64'(sram_a),    64'(0));
    chk({tag, ".d"},         64'(sram_d),    64'(0));
  endtask

  initial begin
    int   bad;
    logic seen;

    tbl[0]  = '{0, 9'h000, 0, 9'h000, 54'h0, 54'h0, 0, 0, 1, 1, ALL1, 9'h000, 54'h0, 0, 54'h0};
    tbl[1]  = '{1, 9'h005, 0, 9'h000, 54'h0, 54'h0, 1, 0, 0, 1, ALL1, 9'h005, 54'h0, 0, 54'h0};
    tbl[2]  = '{0, 9'h000, 0, 9'h000, 54'h0, 54'h0, 0, 0, 1, 1, ALL1, 9'h000, 54'h0, 1, B | 54'h005};
    tbl[3]  = '{0, 9'h000, 1, 9'h1FF, 54'h2A, 54'h3, 0, 1, 0, 0, ~54'h3, 9'h1FF, 54'h2A, 0, 54'h0};
    tbl[4]  = '{1, 9'h1FF, 0, 9'h000, 54'h0, 54'h0, 1, 0, 0, 1, ALL1, 9'h1FF, 54'h0, 0, 54'h0};
    tbl[5]  = '{0, 9'h000, 0, 9'h000, 54'h0, 54'h0, 0, 0, 1, 1, ALL1, 9'h000, 54'h0, 1, B | 54'h1FE};
    tbl[6]  = '{0, 9'h000, 1, 9'h010, ALL1, 54'h0, 0, 1, 0, 0, ALL1, 9'h010, ALL1, 0, 54'h0};
    tbl[7]  = '{1, 9'h010, 0, 9'h000, 54'h0, 54'h0, 1, 0, 0, 1, ALL1, 9'h010, 54'h0, 0, 54'h0};
    tbl[8]  = '{1, 9'h011, 0, 9'h000, 54'h0, 54'h0, 1, 0, 0, 1, ALL1, 9'h011, 54'h0, 1, B | 54'h010};
    tbl[9]  = '{0, 9'h000, 0, 9'h000, 54'h0, 54'h0, 0, 0, 1, 1, ALL1, 9'h000, 54'h0, 1, B | 54'h011};
    tbl[10] = '{1, 9'h020, 1, 9'h021, 54'h55, ALL1, 1, 0, 0, 1, ALL1, 9'h020, 54'h0, 0, 54'h0};
    tbl[11] = '{1, 9'h020, 1, 9'h021, 54'h55, ALL1, 0, 1, 0, 0, 54'h0, 9'h021, 54'h55, 1, B | 54'h020};
    tbl[12] = '{1, 9'h020, 1, 9'h021, 54'h55, ALL1, 1, 0, 0, 1, ALL1, 9'h020, 54'h0, 0, 54'h0};
    tbl[13] = '{1, 9'h020, 1, 9'h021, 54'h55, ALL1, 0, 1, 0, 0, 54'h0, 9'h021, 54'h55, 1, B | 54'h020};
    tbl[14] = '{1, 9'h021, 0, 9'h000, 54'h0, 54'h0, 1, 0, 0, 1, ALL1, 9'h021, 54'h0, 0, 54'h0};
    tbl[15] = '{0, 9'h000, 0, 9'h000, 54'h0, 54'h0, 0, 0, 1, 1, ALL1, 9'h000, 54'h0, 1, 54'h55};

    cpurst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; init_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    cpurst  = 1'b0;
    preload = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rd_req = tbl[i].rr; rd_addr = tbl[i].ra;
      wr_req = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_mask = tbl[i].wm;
      @(negedge clk);
      chk($sformatf("v%0d.rd_gnt", i),  64'(rd_gnt),    64'(tbl[i].egr));
      chk($sformatf("v%0d.wr_gnt", i),  64'(wr_gnt),    64'(tbl[i].egw));
      chk($sformatf("v%0d.cen", i),     64'(sram_cen),  64'(tbl[i].ecen));
      chk($sformatf("v%0d.gwen", i),    64'(sram_gwen), 64'(tbl[i].egwen));
      chk($sformatf("v%0d.wen", i),     64'(sram_wen),  64'(tbl[i].ewen));
      chk($sformatf("v%0d.a", i),       64'(sram_a),    64'(tbl[i].ea));
      chk($sformatf("v%0d.d", i),       64'(sram_d),    64'(tbl[i].ed));
      chk($sformatf("v%0d.rd_vld", i),  64'(rd_vld),    64'(tbl[i].evld));
      chk($sformatf("v%0d.rd_data", i), 64'(rd_data),   64'(tbl[i].erd));
      step();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    step();

`ifdef CT_LSU_SPSRAM_CTRL_INIT_EN
    // clear with a read held from the request cycle onward
    rd_req = 1'b1; rd_addr = 9'h1FF; init_req = 1'b1;
    @(negedge clk);
    chk("clr.req_cycle_rd_gnt", 64'(rd_gnt), 64'(0));
    chk("clr.req_cycle_cen", 64'(sram_cen), 64'(1));
    step();
    init_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (!(init_busy === 1'b1 && rd_gnt === 1'b0 && init_done === 1'b0 && sram_cen === 1'b0 &&
            sram_gwen === 1'b0 && sram_wen === 54'h0 && sram_a === 9'(k) && sram_d === 54'h0)) begin
        if (bad < 4) $display("FAIL clr.cycle%0d: a=%h busy=%b gnt=%b cen=%b", k, sram_a, init_busy, rd_gnt, sram_cen);
        bad++;
      end
      step();
    end
    chk("clr.bad_cycles", 64'(bad), 64'(0));
    @(negedge clk);
    chk("clr.done_pulse", 64'(init_done), 64'(1));
    chk("clr.done_busy", 64'(init_busy), 64'(0));
    chk("clr.done_rd_gnt", 64'(rd_gnt), 64'(0));
    chk("clr.done_cen", 64'(sram_cen), 64'(1));
    step();
    @(negedge clk);
    chk("clr.after_done", 64'(init_done), 64'(0));
    chk("clr.rd_gnt_resumes", 64'(rd_gnt), 64'(1));
    step();
    rd_addr = 9'h000;
    @(negedge clk);
    chk("clr.rd1FF_vld", 64'(rd_vld), 64'(1));
    chk("clr.rd1FF_data", 64'(rd_data), 64'(0));
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chk("clr.rd000_data", 64'(rd_data), 64'(0));
    chk("clr.rd000_vld", 64'(rd_vld), 64'(1));
    step();

    // abort a clear with reset at count 100
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (init_busy && sram_a == 9'd100) seen = 1'b1;
      else step();
    end
    chk("abort.reached_100", 64'(seen), 64'(1));
    cpurst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    step();
    cpurst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (init_done || init_busy) seen = 1'b1;
      step();
    end
    chk("abort.no_done", 64'(seen), 64'(0));
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    @(negedge clk);
    chk("abort.restart_busy", 64'(init_busy), 64'(1));
    chk("abort.restart_a", 64'(sram_a), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      step();
      @(negedge clk);
      if (init_done) seen = 1'b1;
    end
    chk("abort.restart_done", 64'(seen), 64'(1));
    step();
`else
    // without the sequencer, init_req has no effect on arbitration
    rd_req = 1'b1; rd_addr = 9'h005; init_req = 1'b1;
    @(negedge clk);
    chk("noinit.rd_gnt", 64'(rd_gnt), 64'(1));
    chk("noinit.busy", 64'(init_busy), 64'(0));
    step();
    rd_req = 1'b0; init_req = 1'b0;
    @(negedge clk);
    chk("noinit.busy_next", 64'(init_busy), 64'(0));
    chk("noinit.done", 64'(init_done), 64'(0));
    chk("noinit.rd_vld", 64'(rd_vld), 64'(1));
    chk("noinit.rd_data", 64'(rd_data), 64'(B | 54'h005));
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
